motion_cntrl_gen: RTL

Parametrised successor to the line-follower motion controller. It scans NUM_PAIRS IR sensor pairs through the shared A2D, one emitter enabled at a time. It forms a position-weighted steering error and runs a saturating PI loop. It drives signed left/right motor commands to the PWM stage.

---
 rtl/motion_cntrl_gen.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/motion_cntrl_gen.sv
// motion_cntrl_gen: scans NUM_PAIRS IR emitter/sensor pairs through a shared
// A2D, forms a position-weighted steering error and runs a saturating PI loop
// that produces signed left/right motor commands for the PWM stage.
//
// A2D handshake: start_conv is a one-cycle request issued from CONV_R/CONV_L
// with chnnl already valid; chnnl stays stable until the matching cnv_cmplt,
// a one-cycle pulse that qualifies A2D_res. cnv_cmplt is only honoured in
// WAIT_R/WAIT_L and never in the cycle go is low.
module motion_cntrl_gen #(
    parameter int NUM_PAIRS  = 3,
    parameter int A2D_W      = 12,
    parameter int OUT_W      = 11,
    parameter int ERR_W      = 12,
    parameter int I_W        = 12,
    parameter int WSHIFT     = 1,
    parameter int SETTLE_CYC = 4096,
    parameter int CONV_GAP   = 32,
    parameter int P_COEF     = 2,
    parameter int I_SHIFT    = 4,
    parameter int INT_DEC    = 4,
    parameter int BASE       = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            go,
    input  logic                            cnv_cmplt,
    input  logic [A2D_W-1:0]                A2D_res,
    output logic                            start_conv,
    output logic [$clog2(2*NUM_PAIRS)-1:0]  chnnl,
    output logic [NUM_PAIRS-1:0]            IR_en,
    output logic signed [OUT_W-1:0]         lft,
    output logic signed [OUT_W-1:0]         rht,
    output logic                            upd
);

    localparam int CH_W    = $clog2(2*NUM_PAIRS);
    localparam int P_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int CNT_MAX = (SETTLE_CYC > CONV_GAP) ? SETTLE_CYC : CONV_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DEC_W   = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;
    // Room for the signed difference, the largest weight and the pair sum.
    localparam int ACC_W   = A2D_W + 2 + (NUM_PAIRS - 1) * WSHIFT + 2;
    // Wide working width so the PI arithmetic can never wrap before clamping.
    localparam int MW      = ACC_W + ERR_W + I_W + OUT_W + 34;

    localparam logic signed [ERR_W-1:0] ERR_HI = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic signed [ERR_W-1:0] ERR_LO = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic signed [I_W-1:0]   I_HI   = {1'b0, {(I_W-1){1'b1}}};
    localparam logic signed [I_W-1:0]   I_LO   = {1'b1, {(I_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] O_HI   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] O_LO   = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [3:0] {
        IDLE, SETTLE, CONV_R, WAIT_R, GAP, CONV_L, WAIT_L, CALC, UPDATE
    } state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [P_W-1:0]            p, p_n;
    logic                      ld_r, acc_add, do_calc, do_upd, abort;

    logic [A2D_W-1:0]          r_lat;
    logic signed [ACC_W-1:0]   acc, diff, acc_sum;
    logic signed [ERR_W-1:0]   err_sat, err_next;
    logic signed [I_W-1:0]     integ, i_sat, i_new;
    logic [DEC_W-1:0]          dec;
    logic                      dec_hit;
    logic signed [MW-1:0]      sum_w;
    logic signed [OUT_W-1:0]   lft_next, rht_next;

    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [MW-1:0] v);
        if (v > MW'(ERR_HI)) return ERR_HI;
        if (v < MW'(ERR_LO)) return ERR_LO;
        return v[ERR_W-1:0];
    endfunction

    function automatic logic signed [I_W-1:0] sat_i(input logic signed [MW-1:0] v);
        if (v > MW'(I_HI)) return I_HI;
        if (v < MW'(I_LO)) return I_LO;
        return v[I_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [MW-1:0] v);
        if (v > MW'(O_HI)) return O_HI;
        if (v < MW'(O_LO)) return O_LO;
        return v[OUT_W-1:0];
    endfunction

    // State register with scan position and shared settle/gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            p     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            p     <= p_n;
        end
    end

    // Next-state logic; dropping go aborts from any active state first.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p_n     = p;
        ld_r    = 1'b0;
        acc_add = 1'b0;
        do_calc = 1'b0;
        do_upd  = 1'b0;
        abort   = 1'b0;
        if (state != IDLE && !go) begin
            state_n = IDLE;
            cnt_n   = '0;
            p_n     = '0;
            abort   = 1'b1;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                    p_n     = '0;
                end
                SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    state_n = CONV_R;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
                CONV_R: state_n = WAIT_R;
                WAIT_R: if (cnv_cmplt) begin
                    ld_r    = 1'b1;
                    state_n = GAP;
                    cnt_n   = '0;
                end
                GAP: if (cnt == CNT_W'(CONV_GAP - 1)) begin
                    state_n = CONV_L;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
                CONV_L: state_n = WAIT_L;
                WAIT_L: if (cnv_cmplt) begin
                    acc_add = 1'b1;
                    cnt_n   = '0;
                    if (p == P_W'(NUM_PAIRS - 1)) begin
                        state_n = CALC;
                    end else begin
                        p_n     = p + P_W'(1);
                        state_n = SETTLE;
                    end
                end
                CALC: begin
                    do_calc = 1'b1;
                    state_n = UPDATE;
                end
                UPDATE: begin
                    do_upd  = 1'b1;
                    p_n     = '0;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs decoded from state: emitter one-hot over the pair's whole window.
    always_comb begin
        start_conv = (state == CONV_R) || (state == CONV_L);
        chnnl      = CH_W'({p, ((state == CONV_L) || (state == WAIT_L))});
        IR_en      = '0;
        if (state inside {SETTLE, CONV_R, WAIT_R, GAP, CONV_L, WAIT_L})
            IR_en = NUM_PAIRS'(1) << p;
    end

    // PI arithmetic: weighted accumulate, error clamp, decimated integrator.
    always_comb begin
        diff     = ACC_W'(r_lat) - ACC_W'(A2D_res);
        acc_sum  = acc + (diff <<< (int'(p) * WSHIFT));
        err_next = sat_err(MW'(acc));
        dec_hit  = (dec == DEC_W'(INT_DEC - 1));
        i_sat    = sat_i(MW'(integ) + (MW'(err_sat) >>> I_SHIFT));
        i_new    = dec_hit ? i_sat : integ;
        sum_w    = MW'(P_COEF) * MW'(err_sat) + MW'(i_new);
        lft_next = sat_out(MW'(BASE) + sum_w);
        rht_next = sat_out(MW'(BASE) - sum_w);
    end

    // Datapath registers and motor command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat   <= '0;
            acc     <= '0;
            err_sat <= '0;
            integ   <= '0;
            dec     <= '0;
            lft     <= '0;
            rht     <= '0;
            upd     <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (abort) begin
                acc   <= '0;
                integ <= '0;
                lft   <= '0;
                rht   <= '0;
            end
            if (ld_r)    r_lat   <= A2D_res;
            if (acc_add) acc     <= acc_sum;
            if (do_calc) err_sat <= err_next;
            if (do_upd) begin
                integ <= i_new;
                dec   <= dec_hit ? '0 : dec + DEC_W'(1);
                lft   <= lft_next;
                rht   <= rht_next;
                upd   <= 1'b1;
                acc   <= '0;
            end
        end
    end

endmodule
